// File: rtl/dff_arb_pkg.sv
// Shared definitions for the flip-flop bank arbiter.
//   Opcode constants applied by the winning requester to the register bank,
//   and the two-state sequencer encoding.
package dff_arb_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_HOLD  = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/dff_bank_arbiter_rr_picker.sv
// Combinational round-robin selector.
//   req   : per-requester request vector
//   ptr   : index where the search starts (searches upward, wraps N-1 -> 0)
//   valid : at least one request is present
//   idx   : index of the first requester found from ptr
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    valid = 1'b0;
    idx   = '0;
    // Walk from the farthest candidate back to ptr so the closest one wins.
    for (int k = N - 1; k >= 0; k--) begin
      j  = (int'(ptr) + k) % N;
      jj = IW'(j);
      if (req[jj]) begin
        valid = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter/sequencer owning the D, set and reset controls of a
// shared W-bit flip-flop bank.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   req/lock     : per-requester command request and bank-lock request
//   op/data      : per-requester opcode (2 bits each) and load data (W each)
//   q            : register bank contents
//   grant        : one-hot owner of the bank, zero when idle
//   ack          : one-cycle pulse, command of requester i executed
//   busy         : bank is locked by an owner
//   lock_expired : one-cycle pulse when a lock is forcibly released
//
// state  | meaning
// IDLE   | arbitrate every cycle among all requesters from ptr
// LOCKED | only the owner is served; bounded by MAX_LOCK commands
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int           W         = 8,
  parameter int           N         = 4,
  parameter int           MAX_LOCK  = 4,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [2*N-1:0] op,
  input  logic [W*N-1:0] data,
  output logic [W-1:0]   q,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic           lock_expired
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(MAX_LOCK + 1);

  state_t        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          lock_expired_q, lock_expired_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [LW-1:0] left_q, left_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          exec;
  logic [IW-1:0] sel;
  logic [1:0]    sel_op;
  logic [W-1:0]  sel_data;

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_op   = OP_HOLD;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == sel) begin
        sel_op   = op[2*i +: 2];
        sel_data = data[W*i +: W];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    q_d            = q_q;
    grant_d        = grant_q;
    ack_d          = '0;
    lock_expired_d = 1'b0;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    left_d         = left_q;
    exec           = 1'b0;
    sel            = owner_q;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          exec    = 1'b1;
          sel     = pick_idx;
          owner_d = pick_idx;
          grant_d = N'(1) << pick_idx;
          ptr_d   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
          if (lock[pick_idx]) begin
            // left counts the commands still allowed after this one.
            if (MAX_LOCK > 1) begin
              state_d = LOCKED;
              left_d  = LW'(MAX_LOCK - 1);
            end else begin
              lock_expired_d = 1'b1;
              grant_d        = '0;
            end
          end
        end
      end
      LOCKED: begin
        exec = req[owner_q];
        if (!req[owner_q] || !lock[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (left_q == LW'(1)) begin
          state_d        = IDLE;
          grant_d        = '0;
          lock_expired_d = 1'b1;
        end else begin
          left_d = left_q - LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (exec) begin
      ack_d = N'(1) << sel;
      unique case (sel_op)
        OP_LOAD:  q_d = sel_data;
        OP_SET:   q_d = '1;
        OP_CLEAR: q_d = '0;
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      q_q            <= RESET_VAL;
      grant_q        <= '0;
      ack_q          <= '0;
      lock_expired_q <= 1'b0;
      ptr_q          <= '0;
      owner_q        <= '0;
      left_q         <= '0;
    end else begin
      state_q        <= state_d;
      q_q            <= q_d;
      grant_q        <= grant_d;
      ack_q          <= ack_d;
      lock_expired_q <= lock_expired_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      left_q         <= left_d;
    end
  end

  assign q            = q_q;
  assign grant        = grant_q;
  assign ack          = ack_q;
  assign busy         = (state_q == LOCKED);
  assign lock_expired = lock_expired_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
module tb_dff_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [7:0]  op = '0;
  logic [31:0] data = '0;
  logic [7:0]  q;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;
  logic        lock_expired;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [7:0]  op;
    logic [31:0] data;
    logic [7:0]  eq;
    logic [3:0]  egrant;
    logic [3:0]  eack;
    logic        ebusy;
    logic        eexp;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[11];

  dff_bank_arbiter #(.W(8), .N(4), .MAX_LOCK(4), .RESET_VAL(8'h00)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .lock         (lock),
    .op           (op),
    .data         (data),
    .q            (q),
    .grant        (grant),
    .ack          (ack),
    .busy         (busy),
    .lock_expired (lock_expired)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic [3:0] r, logic [3:0] l, logic [7:0] o,
                              logic [31:0] d, logic [7:0] eq, logic [3:0] eg,
                              logic [3:0] ea, logic eb, logic ee);
    vec_t v;
    v.name = nm; v.req = r; v.lock = l; v.op = o; v.data = d;
    v.eq = eq; v.egrant = eg; v.eack = ea; v.ebusy = eb; v.eexp = ee;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one command cycle, queue its expectation, compare after the edge.
  task automatic apply(vec_t v);
    vec_t e;
    req = v.req; lock = v.lock; op = v.op; data = v.data;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.name, ".q"},     32'(q),            32'(e.eq));
      check({e.name, ".grant"}, 32'(grant),        32'(e.egrant));
      check({e.name, ".ack"},   32'(ack),          32'(e.eack));
      check({e.name, ".busy"},  32'(busy),         32'(e.ebusy));
      check({e.name, ".exp"},   32'(lock_expired), 32'(e.eexp));
    end
  endtask

  initial begin
    //                 name      req    lock   op     data          q      grant  ack    busy  exp
    tbl[0]  = mk("load2",  4'b0100, 4'b0000, 8'h00, 32'h00A5_0000, 8'hA5, 4'b0100, 4'b0100, 0, 0);
    tbl[1]  = mk("set3",   4'b1000, 4'b0000, 8'h40, 32'h0,         8'hFF, 4'b1000, 4'b1000, 0, 0);
    tbl[2]  = mk("hold3",  4'b1000, 4'b0000, 8'hC0, 32'h0,         8'hFF, 4'b1000, 4'b1000, 0, 0);
    tbl[3]  = mk("idle_a", 4'b0000, 4'b0000, 8'h00, 32'h0,         8'hFF, 4'b0000, 4'b0000, 0, 0);
    tbl[4]  = mk("rr0",    4'b1111, 4'b0000, 8'h99, 32'h0,         8'hFF, 4'b0001, 4'b0001, 0, 0);
    tbl[5]  = mk("rr1",    4'b1111, 4'b0000, 8'h99, 32'h0,         8'h00, 4'b0010, 4'b0010, 0, 0);
    tbl[6]  = mk("rr2",    4'b1111, 4'b0000, 8'h99, 32'h0,         8'hFF, 4'b0100, 4'b0100, 0, 0);
    tbl[7]  = mk("rr3",    4'b1111, 4'b0000, 8'h99, 32'h0,         8'h00, 4'b1000, 4'b1000, 0, 0);
    tbl[8]  = mk("idle_b", 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h00, 4'b0000, 4'b0000, 0, 0);
    tbl[9]  = mk("load0",  4'b0001, 4'b0000, 8'h00, 32'h0000_0033, 8'h33, 4'b0001, 4'b0001, 0, 0);
    tbl[10] = mk("idle_c", 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h33, 4'b0000, 4'b0000, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst.q", 32'(q), 32'h00);
    check("rst.grant", 32'(grant), 32'h0);
    check("rst.ack", 32'(ack), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.exp", 32'(lock_expired), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) apply(tbl[i]);

    // Lock by requester 1 with requester 0 waiting; fourth command expires the lock.
    apply(mk("lk1", 4'b0011, 4'b0010, 8'h00, 32'h0000_0177, 8'h01, 4'b0010, 4'b0010, 1, 0));
    apply(mk("lk2", 4'b0011, 4'b0010, 8'h00, 32'h0000_0277, 8'h02, 4'b0010, 4'b0010, 1, 0));
    apply(mk("lk3", 4'b0011, 4'b0010, 8'h00, 32'h0000_0377, 8'h03, 4'b0010, 4'b0010, 1, 0));
    apply(mk("lk4", 4'b0011, 4'b0010, 8'h00, 32'h0000_0477, 8'h04, 4'b0000, 4'b0010, 0, 1));
    apply(mk("lk5", 4'b0011, 4'b0010, 8'h00, 32'h0000_0577, 8'h77, 4'b0001, 4'b0001, 0, 0));
    apply(mk("lk6", 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h77, 4'b0000, 4'b0000, 0, 0));

    // Owner drops req after two commands.
    apply(mk("dr1", 4'b0010, 4'b0010, 8'h00, 32'h0000_1100, 8'h11, 4'b0010, 4'b0010, 1, 0));
    apply(mk("dr2", 4'b0010, 4'b0010, 8'h00, 32'h0000_2200, 8'h22, 4'b0010, 4'b0010, 1, 0));
    apply(mk("dr3", 4'b0000, 4'b0010, 8'h00, 32'h0000_2200, 8'h22, 4'b0000, 4'b0000, 0, 0));

    // Final command with lock=0 executes on exit; waiting requester wins next.
    apply(mk("rl1", 4'b1000, 4'b1000, 8'h80, 32'h0,         8'h00, 4'b1000, 4'b1000, 1, 0));
    apply(mk("rl2", 4'b1001, 4'b0000, 8'h40, 32'h0000_005A, 8'hFF, 4'b0000, 4'b1000, 0, 0));
    apply(mk("rl3", 4'b0001, 4'b0000, 8'h40, 32'h0000_005A, 8'h5A, 4'b0001, 4'b0001, 0, 0));

    // Asynchronous reset in the middle of a lock.
    apply(mk("mr1", 4'b0100, 4'b0100, 8'h00, 32'h003C_0000, 8'h3C, 4'b0100, 4'b0100, 1, 0));
    #2;
    reset = 1'b1;
    #1;
    check("mrst.q", 32'(q), 32'h00);
    check("mrst.grant", 32'(grant), 32'h0);
    check("mrst.ack", 32'(ack), 32'h0);
    check("mrst.busy", 32'(busy), 32'h0);
    check("mrst.exp", 32'(lock_expired), 32'h0);
    req = '0; lock = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // ptr back at 0: requester 0 beats requester 3.
    apply(mk("pr1", 4'b1001, 4'b0000, 8'h00, 32'h0000_00C3, 8'hC3, 4'b0001, 4'b0001, 0, 0));
    apply(mk("pr2", 4'b0000, 4'b0000, 8'h00, 32'h0,         8'hC3, 4'b0000, 4'b0000, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
Round-robin arbiter and sequencer that shares one W-bit D-flip-flop register bank between N requesters. Each requester issues load, set, clear or hold commands through a req/ack handshake. A requester can lock the bank for back-to-back commands, bounded by a timeout. The block sits in front of the flip-flop bank and is the only agent that drives its D, set and reset controls.

Parameters:
W, 8, register bank width in bits
N, 4, number of requesters (2..8)
MAX_LOCK, 4, maximum consecutive accepted commands while locked before forced release
RESET_VAL, 0, value of q after reset (W bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  N  per-requester command request
lock  input  N  per-requester lock request, sampled with req
op  input  2*N  per-requester opcode, requester i on bits [2i+1:2i]
data  input  W*N  per-requester load data, requester i on bits [W*i+W-1:W*i]
q  output  W  register bank contents
grant  output  N  one-hot current owner; all zero when idle
ack  output  N  one-cycle pulse; command of requester i executed
busy  output  1  high while in LOCKED
lock_expired  output  1  one-cycle pulse on forced lock release

Behaviour:
- Reset (asynchronous, immediate, including mid-lock): q=RESET_VAL, grant=0, ack=0, busy=0, lock_expired=0, rr pointer=0, lock_cnt=0, state=IDLE.
- Opcodes: 00 LOAD q<=data[i]; 01 SET q<=all ones; 10 CLEAR q<=0; 11 HOLD q unchanged (ack still issued).
- States: IDLE, LOCKED.
- IDLE, no req: all outputs hold, except ack=0 and lock_expired=0.
- IDLE with any req: the winner is the first requester with req high, searching from ptr upward with wrap N-1->0.
  - At the next edge: op executes on q; ack=onehot(winner); grant=onehot(winner); ptr<=(winner+1) mod N.
  - If lock[winner]=1: go to LOCKED with lock_cnt=1. Otherwise stay IDLE and grant returns to 0 on the following edge unless re-granted.
- Latency: req sampled in cycle t; q and ack updated at the edge ending cycle t, visible in cycle t+1. Back-to-back grants to different requesters are possible every cycle.
- Handshake: a requester holds req/op/data stable until it sees ack. A req still high in the ack cycle is re-arbitrated as a new command.
- LOCKED:
  - Only the owner is served; other reqs wait with no ack. grant stays at owner and busy=1.
  - Owner req=1: its op executes every cycle, ack pulses every cycle, lock_cnt increments.
  - Owner req=0 or lock=0: go to IDLE and clear grant at the next edge. A final command with req=1, lock=0 executes and is acked on the exit edge.
  - lock_cnt reaching MAX_LOCK on an accepted command: that command executes, lock_expired pulses with its ack, then forced to IDLE. ptr is already past the owner.
- Simultaneous events:
  - Lock release and another req: the other requester wins in the first IDLE cycle.
  - Reset wins over everything.
- Never more than one ack bit high; q changes only on an acked command.

Decomposition:
- Package dff_arb_pkg holds the opcode constants OP_LOAD/OP_SET/OP_CLEAR/OP_HOLD and the state encoding IDLE/LOCKED.
- One sub-module, rr_picker: combinational round-robin selector. Inputs are req and ptr; outputs are a valid flag and the winner index.
- Opcode decode and the state machine stay in dff_bank_arbiter.

Test Plan:
- Reset release, then req[2]=1, op=LOAD, data[2]=8'hA5 -> next cycle q=8'hA5, ack=4'b0100, grant=4'b0100; then grant=0.
- req=4'b1111, all op=SET/CLEAR alternating, held for 4 cycles, ptr=0 -> acks in order 0,1,2,3, one per cycle; q tracks each op.
- req[1] with lock=1 holding, op=LOAD 8'h01..8'h05, req[0] also high -> acks on 1 only, for 4 commands. The fourth command raises lock_expired and q=8'h04; then req[0] is acked in the next cycle.
- LOCKED owner drops req after 2 commands -> busy falls and grant=0 on the next edge; lock_expired stays 0.
- Reset asserted mid-lock with q=8'h3C -> q=8'h00, grant=0, ack=0, busy=0 immediately without a clock edge; after release, arbitration starts from requester 0.
- op=HOLD from requester 3 with q=8'hFF -> ack=4'b1000, q remains 8'hFF.
